sprite_line_sched: RTL and testbench



---
 rtl/sprite_line_sched.sv | 165 ++++++++++++++++
 tb/tb_sprite_line_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_sched.sv
// Per-scanline bullet sprite scheduler: scans the bullet table in hblank into shadow
// slots and commits them at end of line. Optional macro: SPR_ROUND_ROBIN_EN.
module sprite_line_sched #(
  parameter int N_SPR   = 12,
  parameter int SLOTS   = 4,
  parameter int HALF    = 8,
  parameter int SCAN_HC = 640,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic                clk_25m,
  input  logic                rst_n,
  input  logic [9:0]          hc,
  input  logic [9:0]          vc,
  output logic [3:0]          tbl_idx,
  input  logic [9:0]          tbl_x,
  input  logic [9:0]          tbl_y,
  input  logic                tbl_en,
  output logic [SLOTS-1:0]    slot_vld,
  output logic [SLOTS*10-1:0] slot_x,
  output logic [SLOTS*4-1:0]  slot_row,
  output logic [SLOTS*4-1:0]  slot_id,
  output logic                ovf,
  output logic                busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam int FW = $clog2(SLOTS + 1);
  localparam logic [9:0]    SCAN_HC_C = 10'(SCAN_HC);
  localparam logic [9:0]    HLAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VLAST_C   = 10'(V_TOTAL - 1);
  localparam logic [10:0]   HALF_C    = 11'(HALF);
  localparam logic [4:0]    NSPR_C    = 5'(N_SPR);
  localparam logic [4:0]    LAST_C    = 5'(N_SPR - 1);
  localparam logic [FW-1:0] SLOTS_C   = FW'(SLOTS);

  logic [1:0]            state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [3:0]            prev_q;
  logic [9:0]            tgt_q, tgt_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [SLOTS-1:0]      sh_vld_q, sh_vld_d, act_vld_q;
  logic [SLOTS-1:0][9:0] sh_x_q, sh_x_d, act_x_q;
  logic [SLOTS-1:0][3:0] sh_row_q, sh_row_d, act_row_q;
  logic [SLOTS-1:0][3:0] sh_id_q, sh_id_d, act_id_q;
  logic                  sh_ovf_q, sh_ovf_d, act_ovf_q;
  logic [3:0]            start;
  logic [4:0]            sum;
  logic [10:0]           tgt_w, y_w;
  logic [3:0]            row;
  logic                  eval, hit, commit;

  assign sum     = {1'b0, start} + cnt_q;
  assign tbl_idx = (state_q == S_SCAN) ? ((sum >= NSPR_C) ? 4'(sum - NSPR_C) : sum[3:0]) : 4'd0;
  assign busy    = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign commit  = (state_q != S_IDLE) && (hc == HLAST_C);

  // Table data lags the index by one cycle, so a SCAN cycle judges the previous index.
  assign eval  = ((state_q == S_SCAN) && (cnt_q != 5'd0)) || (state_q == S_DRAIN);
  assign tgt_w = {1'b0, tgt_q};
  assign y_w   = {1'b0, tbl_y};
  assign hit   = eval && tbl_en && (tgt_w + HALF_C >= y_w) && (tgt_w < y_w + HALF_C);
  assign row   = 4'(tgt_w + HALF_C - y_w);

`ifdef SPR_ROUND_ROBIN_EN
  logic [3:0] start_q;
  always_ff @(posedge clk_25m) begin
    if (!rst_n)                       start_q <= '0;
    else if (commit && vc == VLAST_C) start_q <= (start_q == 4'(N_SPR - 1)) ? 4'd0 : start_q + 4'd1;
  end
  assign start = start_q;
`else
  assign start = 4'd0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    fill_d   = fill_q;
    sh_vld_d = sh_vld_q;
    sh_x_d   = sh_x_q;
    sh_row_d = sh_row_q;
    sh_id_d  = sh_id_q;
    sh_ovf_d = sh_ovf_q;
    case (state_q)
      S_IDLE: if (hc == SCAN_HC_C) begin
        state_d  = S_SCAN;
        cnt_d    = '0;
        tgt_d    = (vc == VLAST_C) ? 10'd0 : vc + 10'd1;
        fill_d   = '0;
        sh_vld_d = '0;
        sh_x_d   = '0;
        sh_row_d = '0;
        sh_id_d  = '0;
        sh_ovf_d = 1'b0;
      end
      S_SCAN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_C) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: ;
    endcase
    if (hit) begin
      if (fill_q == SLOTS_C) sh_ovf_d = 1'b1;
      else begin
        for (int k = 0; k < SLOTS; k++) begin
          if (fill_q == FW'(k)) begin
            sh_vld_d[k] = 1'b1;
            sh_x_d[k]   = tbl_x;
            sh_row_d[k] = row;
            sh_id_d[k]  = prev_q;
          end
        end
        fill_d = fill_q + 1'b1;
      end
    end
    // A late end of line still commits the partial fill and abandons the scan.
    if (commit) state_d = S_IDLE;
  end

  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prev_q    <= '0;
      tgt_q     <= '0;
      fill_q    <= '0;
      sh_vld_q  <= '0;
      sh_x_q    <= '0;
      sh_row_q  <= '0;
      sh_id_q   <= '0;
      sh_ovf_q  <= 1'b0;
      act_vld_q <= '0;
      act_x_q   <= '0;
      act_row_q <= '0;
      act_id_q  <= '0;
      act_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= tbl_idx;
      tgt_q    <= tgt_d;
      fill_q   <= fill_d;
      sh_vld_q <= sh_vld_d;
      sh_x_q   <= sh_x_d;
      sh_row_q <= sh_row_d;
      sh_id_q  <= sh_id_d;
      sh_ovf_q <= sh_ovf_d;
      if (commit) begin
        act_vld_q <= sh_vld_q;
        act_x_q   <= sh_x_q;
        act_row_q <= sh_row_q;
        act_id_q  <= sh_id_q;
        act_ovf_q <= sh_ovf_q;
      end
    end
  end

  assign slot_vld = act_vld_q;
  assign slot_x   = act_x_q;
  assign slot_row = act_row_q;
  assign slot_id  = act_id_q;
  assign ovf      = act_ovf_q;
endmodule

// File: tb/tb_sprite_line_sched.sv
// Bench for sprite_line_sched: table vectors, hand sequences and a randomized
// per-line reference model; only the hblank part of each line is clocked.
module tb_sprite_line_sched;
  localparam int N_SPR = 12, SLOTS = 4, HALF = 8, SCAN_HC = 640, H_TOTAL = 800, V_TOTAL = 525;
`ifdef SPR_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk_25m = 1'b0, rst_n = 1'b0;
  logic [9:0] hc = '0, vc = '0, tbl_x = '0, tbl_y = '0;
  logic tbl_en = 1'b0;
  logic [3:0] tbl_idx;
  logic [SLOTS-1:0] slot_vld;
  logic [SLOTS*10-1:0] slot_x;
  logic [SLOTS*4-1:0] slot_row, slot_id;
  logic ovf, busy;

  always #20 clk_25m = ~clk_25m;

  sprite_line_sched #(.N_SPR(N_SPR), .SLOTS(SLOTS), .HALF(HALF), .SCAN_HC(SCAN_HC),
                      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .hc(hc), .vc(vc), .tbl_idx(tbl_idx),
    .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_en(tbl_en), .slot_vld(slot_vld), .slot_x(slot_x),
    .slot_row(slot_row), .slot_id(slot_id), .ovf(ovf), .busy(busy));

  int n_cmp = 0, n_bad = 0;
  int bx[16], by[16];
  bit ben[16];
  int start_m = 0;

  typedef struct {
    int         scen;
    int         line;
    logic [3:0] vld;
    logic [15:0] ids;
    int         x0;
    int         row0;
    bit         o;
  } vec_t;
  vec_t vt[12];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_vld"}, 64'(slot_vld), 64'd0);
    chk({tag, "_x"},   64'(slot_x),   64'd0);
    chk({tag, "_row"}, 64'(slot_row), 64'd0);
    chk({tag, "_id"},  64'(slot_id),  64'd0);
    chk({tag, "_ovf"}, 64'(ovf),      64'd0);
    chk({tag, "_busy"}, 64'(busy),    64'd0);
    chk({tag, "_idx"}, 64'(tbl_idx),  64'd0);
  endtask

  // One clock; the table answers with the entry addressed during the previous cycle.
  task automatic step();
    logic [3:0] idx;
    idx = tbl_idx;
    @(posedge clk_25m);
    #1;
    tbl_x  = 10'(bx[idx]);
    tbl_y  = 10'(by[idx]);
    tbl_en = ben[idx];
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hc = '0; vc = '0;
    step(); step();
    rst_n = 1'b1;
    start_m = 0;
  endtask

  // Clocks the blanking part of line v; on return the outputs hold line v+1's slots.
  task automatic run_line(int v, int rst_at);
    int bcnt, bfirst;
    bcnt = 0; bfirst = -1;
    vc = 10'(v);
    for (int h = SCAN_HC - 4; h < H_TOTAL; h++) begin
      hc = 10'(h);
      rst_n = (h == rst_at) ? 1'b0 : 1'b1;
      if (busy) begin
        bcnt++;
        if (bfirst < 0) bfirst = h;
      end
      step();
      if (h == rst_at) chk_zero($sformatf("rst_l%0d", v));
    end
    rst_n = 1'b1;
    hc = '0;
    vc = 10'((v + 1) % V_TOTAL);
    if (rst_at < 0) begin
      chk($sformatf("busy_len_l%0d", v), 64'(bcnt), 64'(N_SPR + 1));
      chk($sformatf("busy_start_l%0d", v), 64'(bfirst), 64'(SCAN_HC + 1));
      if (RR && v == V_TOTAL - 1) start_m = (start_m + 1) % N_SPR;
    end
  endtask

  // Reference: walk the table in scan order, keep the first SLOTS bullets covering the line.
  task automatic model(int line, output logic [3:0] vld, output logic [39:0] xs,
                       output logic [15:0] rows, output logic [15:0] ids, output logic o);
    int k, j;
    k = 0; vld = '0; xs = '0; rows = '0; ids = '0; o = 1'b0;
    for (int i = 0; i < N_SPR; i++) begin
      j = (start_m + i) % N_SPR;
      if (ben[j] && line + HALF >= by[j] && line < by[j] + HALF) begin
        if (k < SLOTS) begin
          vld[k] = 1'b1;
          xs[k*10 +: 10] = 10'(bx[j]);
          rows[k*4 +: 4] = 4'(line + HALF - by[j]);
          ids[k*4 +: 4]  = 4'(j);
          k++;
        end else o = 1'b1;
      end
    end
  endtask

  task automatic chk_model(string tag, logic [3:0] ev, logic [39:0] ex,
                           logic [15:0] er, logic [15:0] ei, logic eo);
    chk({tag, "_vld"}, 64'(slot_vld), 64'(ev));
    chk({tag, "_x"},   64'(slot_x),   64'(ex));
    chk({tag, "_row"}, 64'(slot_row), 64'(er));
    chk({tag, "_id"},  64'(slot_id),  64'(ei));
    chk({tag, "_ovf"}, 64'(ovf),      64'(eo));
  endtask

  task automatic apply_scen(int s);
    for (int j = 0; j < 16; j++) begin bx[j] = 0; by[j] = 0; ben[j] = 1'b0; end
    case (s)
      1: begin bx[3] = 100; by[3] = 50; ben[3] = 1'b1; end
      2: for (int j = 0; j < 6; j++) begin bx[j] = 300 + j; by[j] = 200; ben[j] = 1'b1; end
      3: begin bx[7] = 20; by[7] = 3; ben[7] = 1'b1; end
      default: ;
    endcase
  endtask

  initial begin
    logic [3:0] ev;
    logic [39:0] ex;
    logic [15:0] er, ei;
    logic eo;
    int lines[6];

    vt[0]  = '{1, 41,  4'h0, 16'h0000, 0,   0,  1'b0};
    vt[1]  = '{1, 42,  4'h1, 16'h0003, 100, 0,  1'b0};
    vt[2]  = '{1, 49,  4'h1, 16'h0003, 100, 7,  1'b0};
    vt[3]  = '{1, 57,  4'h1, 16'h0003, 100, 15, 1'b0};
    vt[4]  = '{1, 58,  4'h0, 16'h0000, 0,   0,  1'b0};
    vt[5]  = '{2, 192, 4'hF, 16'h3210, 300, 0,  1'b1};
    vt[6]  = '{2, 207, 4'hF, 16'h3210, 300, 15, 1'b1};
    vt[7]  = '{2, 208, 4'h0, 16'h0000, 0,   0,  1'b0};
    vt[8]  = '{3, 0,   4'h1, 16'h0007, 20,  5,  1'b0};
    vt[9]  = '{3, 1,   4'h1, 16'h0007, 20,  6,  1'b0};
    vt[10] = '{3, 10,  4'h1, 16'h0007, 20,  15, 1'b0};
    vt[11] = '{3, 11,  4'h0, 16'h0000, 0,   0,  1'b0};

    apply_scen(0);
    do_reset();
    chk_zero("reset");

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      apply_scen(vt[i].scen);
      run_line((vt[i].line == 0) ? V_TOTAL - 1 : vt[i].line - 1, -1);
      chk($sformatf("vec%0d_vld", i),  64'(slot_vld),     64'(vt[i].vld));
      chk($sformatf("vec%0d_id", i),   64'(slot_id),      64'(vt[i].ids));
      chk($sformatf("vec%0d_x0", i),   64'(slot_x[9:0]),  64'(vt[i].x0));
      chk($sformatf("vec%0d_row0", i), 64'(slot_row[3:0]), 64'(vt[i].row0));
      chk($sformatf("vec%0d_ovf", i),  64'(ovf),          64'(vt[i].o));
    end

    // Empty table over two passes including the frame wrap
    apply_scen(0);
    lines = '{0, 1, 100, 300, 523, 524};
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 6; i++) begin
        run_line(lines[i], -1);
        chk($sformatf("empty_vld_l%0d", lines[i]), 64'(slot_vld), 64'd0);
        chk($sformatf("empty_ovf_l%0d", lines[i]), 64'(ovf), 64'd0);
      end

    // Randomized tables clustered around the target line
    for (int it = 0; it < 80; it++) begin
      int c, tl;
      c  = (it % 10 == 0) ? V_TOTAL - 1 : int'($urandom_range(0, V_TOTAL - 1));
      tl = (c == V_TOTAL - 1) ? 0 : c + 1;
      for (int j = 0; j < 16; j++) begin
        ben[j] = (j < N_SPR) && ($urandom_range(0, 3) != 0);
        by[j]  = tl + int'($urandom_range(0, 24)) - 12;
        if (by[j] < 0) by[j] = 0;
        bx[j]  = int'($urandom_range(0, 639));
      end
      model(tl, ev, ex, er, ei, eo);
      run_line(c, -1);
      chk_model($sformatf("rnd%0d", it), ev, ex, er, ei, eo);
    end

    // Reset in the middle of a scan
    apply_scen(1);
    run_line(45, -1);
    chk("pre_rst_vld", 64'(slot_vld), 64'd1);
    run_line(46, SCAN_HC + 5);
    start_m = 0;
    chk_zero("post_rst_line");
    run_line(47, -1);
    model(48, ev, ex, er, ei, eo);
    chk_model("after_rst", ev, ex, er, ei, eo);
    chk("after_rst_row", 64'(slot_row[3:0]), 64'd6);

`ifdef SPR_ROUND_ROBIN_EN
    begin
      logic [15:0] rr_ids[3];
      rr_ids = '{16'h3210, 16'h4321, 16'h5432};
      apply_scen(2);
      do_reset();
      for (int f = 0; f < 3; f++) begin
        run_line(191, -1);
        chk($sformatf("rr_f%0d_id", f), 64'(slot_id), 64'(rr_ids[f]));
        chk($sformatf("rr_f%0d_ovf", f), 64'(ovf), 64'd1);
        run_line(V_TOTAL - 1, -1);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
